// File: rtl/maze_probe.sv
// Frame-triggered maze probe: samples the tile code next to each side of the player via a maze ROM.
// Optional `TUNNEL_PASS_EN: out-of-range L/R probes within the tunnel rows report open (5'h00).
module maze_probe #(
  parameter int TILE      = 14,
  parameter int MAZE_COLS = 28,
  parameter int MAZE_ROWS = 31,
  parameter int TUN_Y_MIN = 195,
  parameter int TUN_Y_MAX = 223
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [9:0] rom_addr,
  input  logic [4:0] rom_data,
  output logic [4:0] mapL,
  output logic [4:0] mapR,
  output logic [4:0] mapT,
  output logic [4:0] mapB,
  output logic       probe_valid
);

  localparam int          PIX_W  = TILE * MAZE_COLS;
  localparam int          PIX_H  = TILE * MAZE_ROWS;
  localparam logic [9:0]  COLS_V = 10'(MAZE_COLS);
  localparam logic [9:0]  TILE_V = 10'(TILE);
  localparam logic [4:0]  BLOCKED = 5'h1F;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, CALC, DIV, ADDR, WAIT, LATCH, DONE
  } state_t;

  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_T, DIR_B} dir_t;

  state_t r_state, w_next;
  dir_t   r_dir;

  logic       r_fs1, r_fs2, r_fs3;
  logic       r_pend;
  logic [9:0] r_x, r_y, r_s;
  logic [9:0] r_remx, r_remy, r_qx, r_qy;
  logic       r_oor;
  logic [9:0] r_rom_addr;
  logic [4:0] r_sh [4];
  logic [4:0] r_mapL, r_mapR, r_mapT, r_mapB;
  logic       r_valid;

  logic               w_event;
  logic signed [10:0] w_x, w_y, w_s1, w_px, w_py;
  logic               w_oor;
  logic               w_x_done, w_y_done;
  logic [9:0]         w_rom_addr;
  logic [4:0]         w_oor_code, w_code;

  assign w_event = r_fs2 & ~r_fs3;

  assign w_x  = signed'({1'b0, r_x});
  assign w_y  = signed'({1'b0, r_y});
  assign w_s1 = signed'({1'b0, r_s}) + 11'sd1;

  always_comb begin
    w_px = w_x;
    w_py = w_y;
    case (r_dir)
      DIR_L:   w_px = w_x - w_s1;
      DIR_R:   w_px = w_x + w_s1;
      DIR_T:   w_py = w_y - w_s1;
      default: w_py = w_y + w_s1;
    endcase
  end

  assign w_oor = w_px[10] | w_py[10] | (w_px[9:0] >= 10'(PIX_W)) | (w_py[9:0] >= 10'(PIX_H));

  assign w_x_done = r_remx < TILE_V;
  assign w_y_done = r_remy < TILE_V;

  // row*MAZE_COLS as a sum of shifted rows, one term per set bit of the constant
  always_comb begin
    w_rom_addr = r_qx;
    for (int unsigned i = 0; i < 10; i++) begin
      if (COLS_V[i]) w_rom_addr = w_rom_addr + (r_qy << i);
    end
  end

`ifdef TUNNEL_PASS_EN
  assign w_oor_code = ((r_dir == DIR_L || r_dir == DIR_R) &&
                       int'(w_py) >= TUN_Y_MIN && int'(w_py) <= TUN_Y_MAX) ? 5'h00 : BLOCKED;
`else
  assign w_oor_code = BLOCKED;
`endif

  assign w_code = r_oor ? w_oor_code : rom_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_event) w_next = CAPTURE;
      CAPTURE: w_next = CALC;
      CALC:    w_next = w_oor ? LATCH : DIV;
      DIV:     if (w_x_done && w_y_done) w_next = ADDR;
      ADDR:    w_next = WAIT;
      WAIT:    w_next = LATCH;
      LATCH:   w_next = (r_dir == DIR_B) ? DONE : CALC;
      DONE:    w_next = (r_pend || w_event) ? CAPTURE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_fs1   <= 1'b0;
      r_fs2   <= 1'b0;
      r_fs3   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fs1   <= frame_clk;
      r_fs2   <= r_fs1;
      r_fs3   <= r_fs2;
      if (r_state == DONE)                  r_pend <= 1'b0;
      else if (r_state != IDLE && w_event)  r_pend <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dir      <= DIR_L;
      r_x        <= '0;
      r_y        <= '0;
      r_s        <= '0;
      r_remx     <= '0;
      r_remy     <= '0;
      r_qx       <= '0;
      r_qy       <= '0;
      r_oor      <= 1'b0;
      r_rom_addr <= '0;
      for (int unsigned i = 0; i < 4; i++) r_sh[i] <= BLOCKED;
      r_mapL     <= BLOCKED;
      r_mapR     <= BLOCKED;
      r_mapT     <= BLOCKED;
      r_mapB     <= BLOCKED;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        CAPTURE: begin
          r_x   <= BallX;
          r_y   <= BallY;
          r_s   <= BallS;
          r_dir <= DIR_L;
        end
        CALC: begin
          r_oor  <= w_oor;
          r_remx <= w_px[9:0];
          r_remy <= w_py[9:0];
          r_qx   <= '0;
          r_qy   <= '0;
        end
        DIV: begin
          if (!w_x_done) begin
            r_remx <= r_remx - TILE_V;
            r_qx   <= r_qx + 10'd1;
          end
          if (!w_y_done) begin
            r_remy <= r_remy - TILE_V;
            r_qy   <= r_qy + 10'd1;
          end
        end
        ADDR: r_rom_addr <= w_rom_addr;
        LATCH: begin
          r_sh[r_dir] <= w_code;
          r_dir       <= dir_t'(r_dir + 2'd1);
          // Outputs load on entry to DONE so maps and strobe are both valid during DONE
          if (r_dir == DIR_B) begin
            r_mapL  <= r_sh[DIR_L];
            r_mapR  <= r_sh[DIR_R];
            r_mapT  <= r_sh[DIR_T];
            r_mapB  <= w_code;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr    = r_rom_addr;
  assign mapL        = r_mapL;
  assign mapR        = r_mapR;
  assign mapT        = r_mapT;
  assign mapB        = r_mapB;
  assign probe_valid = r_valid;

endmodule

// File: doc/maze_probe.md
MAZE_PROBE -- requirements
Module: maze_probe

Interface
REQ-001 Parameters SHALL be: TILE, default 14, tile edge in pixels; MAZE_COLS, default 28, tiles per row; MAZE_ROWS, default 31, tile rows; TUN_Y_MIN, default 195, lowest tunnel Y; TUN_Y_MAX, default 223, highest tunnel Y.
REQ-002 Clk  in  1  block clock.
REQ-003 Reset_n  in  1  asynchronous, active-low reset.
REQ-004 frame_clk  in  1  frame strobe, asynchronous to Clk.
REQ-005 BallX, BallY  in  10 each  player centre position.
REQ-006 BallS  in  10  player half-size.
REQ-007 rom_addr  out  10  maze ROM address, tile index = row*MAZE_COLS+col.
REQ-008 rom_data  in  5  maze ROM tile code, 0 = open; valid exactly 1 Clk after rom_addr changes.
REQ-009 mapL, mapR, mapT, mapB  out  5 each  tile code adjacent to the player on each side.
REQ-010 probe_valid  out  1  one-Clk pulse when the map outputs update.

Function
REQ-011 frame_clk SHALL pass through a 2-FF synchronizer, and a synchronized rising edge SHALL be the frame event.
REQ-012 FSM states SHALL be IDLE, CAPTURE, CALC, DIV, ADDR, WAIT, LATCH, and DONE.
REQ-013 IDLE SHALL go to CAPTURE on a frame event, and CAPTURE SHALL latch BallX, BallY, and BallS, clear the direction index to L, then go to CALC.
REQ-014 The direction order SHALL be L, R, T, B.
REQ-015 Probe points SHALL be L=(X-S-1,Y), R=(X+S+1,Y), T=(X,Y-S-1), B=(X,Y+S+1), computed in 11-bit signed arithmetic.
REQ-016 CALC SHALL mark a probe out-of-range if px<0, py<0, px>=TILE*MAZE_COLS, or py>=TILE*MAZE_ROWS.
REQ-017 An out-of-range probe SHALL skip to LATCH with code 5'h1F, subject to REQ-029.
REQ-018 DIV SHALL compute col=px/TILE and row=py/TILE by repeated subtraction, with one TILE subtraction per Clk on each coordinate in parallel, and SHALL exit when both remainders are below TILE.
REQ-019 ADDR SHALL drive rom_addr=row*MAZE_COLS+col, computed with shifts and adds and no multiplier, and SHALL hold it through WAIT.
REQ-020 LATCH SHALL store rom_data, or the out-of-range code, into that direction's shadow register, advance the direction, and go to CALC or, after B, to DONE.
REQ-021 DONE SHALL copy all four shadow registers to mapL/R/T/B in the same Clk and assert probe_valid for exactly that Clk.
REQ-022 The map outputs SHALL change only in DONE and SHALL hold between DONE pulses.
REQ-023 probe_valid SHALL assert no more than 150 Clk after the frame event.
REQ-024 A frame event while not in IDLE, including in DONE, SHALL set a pending flag.
REQ-025 DONE with pending set SHALL clear the flag and go to CAPTURE, otherwise it SHALL go to IDLE.
REQ-026 Multiple frame events during one sweep SHALL collapse into a single pending flag.
REQ-027 BallX, BallY, and BallS changes after CAPTURE SHALL NOT affect the current sweep.

Reset
REQ-028 On Reset_n low: state=IDLE; pending=0; synchronizer=0; rom_addr=0; probe_valid=0; mapL=mapR=mapT=mapB=5'h1F; shadow registers=5'h1F. A mid-sweep reset SHALL abandon the sweep, with outputs at the reset values and no probe_valid.

Configuration
REQ-029 With TUNNEL_PASS_EN defined, an out-of-range L or R probe whose py is within [TUN_Y_MIN, TUN_Y_MAX] SHALL report 5'h00, and all other out-of-range probes SHALL report 5'h1F.
REQ-030 With TUNNEL_PASS_EN undefined, every out-of-range probe SHALL report 5'h1F.

Verification
REQ-031 Centre: ROM(a)=a[4:0], X=202, Y=253, S=13, one frame -> ROM addresses 517, 519, 490, 546 in that order; mapL=5'h05, mapR=5'h07, mapT=5'h0A, mapB=5'h02; probe_valid pulses once within 150 Clk.
REQ-032 Tunnel: X=5, Y=210, S=13, TUNNEL_PASS_EN defined -> mapL=5'h00 with no ROM access for L; with the macro undefined -> mapL=5'h1F.
REQ-033 Top-edge clip: Y=10, S=13 -> mapT=5'h1F with no ROM access for T; the other three outputs follow the ROM.
REQ-034 Overlap: a second frame event 20 Clk after the first -> two probe_valid pulses; the second sweep starts in the Clk after the first DONE; a third event in the same window adds no extra sweep.
REQ-035 Reset mid-sweep: Reset_n low during DIV of T -> outputs are 5'h1F and probe_valid=0; after release, the next frame produces a full L, R, T, B sweep.
